ex_iter_multdiv: RTL and testbench
==================================

// Module: ex_iter_multdiv
// PURPOSE
//  Parametrised iterative multiply/divide unit serving the EX stage's MULT/MULTU/DIV/DIVU path.
//  EX drives start/op/operands and stalls until done; the unit returns the {HI,LO} pair, which EX writes to HILO.
//  Replaces a fixed-width single-shot multdiv with a DATA_W-generic radix-2 engine.
//  Adds flush cancel, divide-by-zero early exit and defined signed corner cases.
// PARAMETERS
//  DATA_W   32   operand width; result is 2*DATA_W
//  CNT_W    $clog2(DATA_W)+1   iteration counter width (derived, do not override)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  start      in   1          request; sampled only in IDLE
//  op         in   2          00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  operand_1  in   DATA_W     multiplicand / dividend
//  operand_2  in   DATA_W     multiplier / divisor
//  flush      in   1          cancel any operation in flight (pipeline exception/flush)
//  busy       out  1          high in MUL, DIV and DONE states
//  done       out  1          one-cycle pulse: result valid this cycle
//  result     out  2*DATA_W   {HI,LO}. MUL: HI=upper, LO=lower product; DIV: HI=remainder, LO=quotient
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  States: IDLE, MUL, DIV, DONE.
//   IDLE: on start && !flush, latch op and operands; go to MUL (op[1]=0) or DIV (op[1]=1).
//     Counter=DATA_W.
//     DIV with operand_2==0: go straight to DONE. Latency: done in the 1st cycle after the start edge.
//     Divide-by-zero result: HI=operand_1, LO={DATA_W{1'b1}}.
//   MUL/DIV: one radix-2 step per cycle; counter decrements; last step at counter==1, then DONE.
//   DONE: done=1 for exactly one cycle; return to IDLE unconditionally.
//     start in this cycle is ignored.
//  Latency: the start edge is cycle 0; done=1 in cycle DATA_W+1 (33 for DATA_W=32). No other early exit.
//  Signed ops (MULT, DIV): operands converted to magnitudes at latch.
//   Unsigned ops (MULTU, DIVU): raw operands used.
//  MUL: shift-add over 2*DATA_W accumulator.
//   If operand signs differ, the final product is two's-complement negated (2*DATA_W bits).
//  DIV: restoring division with a DATA_W+1-bit partial remainder.
//   If operand signs differ, the quotient is negated.
//   The remainder takes the dividend's sign. |remainder| < |divisor|.
//  Corner: DIV MIN/-1 gives LO=MIN (wraps), HI=0. MULT MIN*MIN gives 2^(2*DATA_W-2).
//  Sign fix-up happens on the edge entering DONE; result is a register.
//   result is stable from DONE until the next accepted operation completes.
//  flush has priority over everything except rst.
//   In MUL/DIV/DONE, flush forces IDLE on the next edge. done is not asserted (also suppressed combinationally in DONE).
//   result keeps its previous value.
//   flush && start in IDLE: start is ignored.
//  start while busy: ignored; the latched operands are unaffected by input changes mid-operation.
//  Async reset mid-operation aborts immediately; no done is produced.
//  Unused op encodings: none (2-bit op fully decoded).
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 33.
//   result = 0xFFFFFFFE_00000001; busy high cycles 1..33.
//  MULT 0xFFFFFFFD(-3)*7 -> result = 0xFFFFFFFF_FFFFFFEB (-21).
//   MULT 0x80000000*0x80000000 -> result = 0x40000000_00000000.
//  DIV -7/2 -> HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3).
//   DIVU 100/7 -> HI=2, LO=14.
//   DIV 0x80000000/0xFFFFFFFF -> HI=0, LO=0x80000000.
//  DIVU 5/0 -> done at cycle 1.
//   result = 0x00000005_FFFFFFFF.
//  Flush at cycle 10 of a MULT -> IDLE next cycle.
//   No done; result unchanged. A following start completes normally 33 cycles later.
//  Async rst asserted mid-DIV -> outputs 0 immediately.
//   start held high through DONE -> exactly one done pulse; re-accept only after IDLE.
//  Also run DATA_W=8 random signed/unsigned sweep vs reference model; done at cycle 9.

Source files
------------

// File: rtl/ex_iter_multdiv_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
//   start      EX -> unit   request, sampled only while the unit is idle
//   op         EX -> unit   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_1  EX -> unit   multiplicand / dividend
//   operand_2  EX -> unit   multiplier / divisor
//   flush      EX -> unit   cancel any operation in flight
//   busy       unit -> EX   operation in progress (EX stalls)
//   done       unit -> EX   one-cycle pulse, result valid
//   result     unit -> EX   {HI,LO}
interface ex_iter_multdiv_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_W-1:0]     operand_1;
    logic [DATA_W-1:0]     operand_2;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [2*DATA_W-1:0]   result;

    modport master (
        output start, op, operand_1, operand_2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand_1, operand_2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/ex_iter_multdiv.sv
// Iterative radix-2 multiply/divide unit for the EX stage MULT/MULTU/DIV/DIVU path.
// One shift-add (multiply) or restoring-division step per cycle; DATA_W steps per operation,
// with an early exit only for divide-by-zero.
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   slave side of ex_iter_multdiv_if (start/op/operands/flush in, busy/done/result out)
module ex_iter_multdiv #(
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    ex_iter_multdiv_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  neg_q;       // operand signs differ: negate product / quotient
    logic                  rem_neg_q;   // dividend negative: negate remainder
    logic [2*DATA_W-1:0]   acc_q;       // product accumulator
    logic [2*DATA_W-1:0]   mcand_q;     // multiplicand, shifted left each step
    logic [DATA_W-1:0]     mplier_q;    // multiplier (shifted right) or divisor (static)
    logic [DATA_W-1:0]     quot_q;      // dividend bits shift out as quotient bits shift in
    logic [DATA_W:0]       rem_q;       // partial remainder
    logic [2*DATA_W-1:0]   result_q;
    logic                  done_q;

    // Operand magnitudes for signed ops; MIN maps onto itself, which is the correct
    // unsigned magnitude 2^(DATA_W-1).
    logic                  signed_op;
    logic                  op1_neg;
    logic                  op2_neg;
    logic [DATA_W-1:0]     mag1;
    logic [DATA_W-1:0]     mag2;

    always_comb begin
        signed_op = ~bus.op[0];
        op1_neg   = signed_op & bus.operand_1[DATA_W-1];
        op2_neg   = signed_op & bus.operand_2[DATA_W-1];
        mag1      = op1_neg ? -bus.operand_1 : bus.operand_1;
        mag2      = op2_neg ? -bus.operand_2 : bus.operand_2;
    end

    // Single-step datapath plus the sign fix-up applied on the final step.
    logic [2*DATA_W-1:0]   mul_acc_nxt;
    logic [2*DATA_W-1:0]   mul_fix;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_trial;
    logic [DATA_W:0]       div_rem_nxt;
    logic [DATA_W-1:0]     div_quot_nxt;
    logic [DATA_W-1:0]     quot_fix;
    logic [DATA_W-1:0]     rem_fix;

    always_comb begin
        mul_acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_fix      = neg_q ? -mul_acc_nxt : mul_acc_nxt;
        div_shift    = {rem_q[DATA_W-1:0], quot_q[DATA_W-1]};
        div_trial    = div_shift - {1'b0, mplier_q};
        // Top bit of the trial set means the subtraction borrowed: restore.
        div_rem_nxt  = div_trial[DATA_W] ? div_shift : div_trial;
        div_quot_nxt = {quot_q[DATA_W-2:0], ~div_trial[DATA_W]};
        quot_fix     = neg_q ? -div_quot_nxt : div_quot_nxt;
        rem_fix      = rem_neg_q ? -div_rem_nxt[DATA_W-1:0] : div_rem_nxt[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else if (bus.flush) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        neg_q     <= op1_neg ^ op2_neg;
                        rem_neg_q <= op1_neg;
                        cnt_q     <= CNT_W'(DATA_W);
                        acc_q     <= '0;
                        mcand_q   <= {{DATA_W{1'b0}}, mag1};
                        mplier_q  <= mag2;
                        quot_q    <= mag1;
                        rem_q     <= '0;
                        if (bus.op[1] && (bus.operand_2 == '0)) begin
                            result_q <= {bus.operand_1, {DATA_W{1'b1}}};
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            state_q <= bus.op[1] ? StDiv : StMul;
                        end
                    end
                end
                StMul: begin
                    acc_q    <= mul_acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= mul_fix;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDiv: begin
                    rem_q  <= div_rem_nxt;
                    quot_q <= div_quot_nxt;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= {rem_fix, quot_fix};
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q & ~bus.flush;
    assign bus.result = result_q;
endmodule

// File: tb/tb_ex_iter_multdiv.sv
// Self-checking bench for ex_iter_multdiv: directed corner cases at DATA_W=32 and randomized
// sweeps at DATA_W=32 and DATA_W=8 against a plain-arithmetic reference model.
module tb_ex_iter_multdiv;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ex_iter_multdiv_if #(.DATA_W(32)) bus32 ();
    ex_iter_multdiv_if #(.DATA_W(8))  bus8 ();

    ex_iter_multdiv #(.DATA_W(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    ex_iter_multdiv #(.DATA_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on sign- or zero-extended 64-bit values.
    function automatic logic [63:0] ref_model(input int w, input logic [1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        mask_w;
        logic [63:0]        mask_r;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        q;
        logic [63:0]        r;
        mask_w = (64'd1 << w) - 64'd1;
        mask_r = (w == 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
        ua = {32'd0, a} & mask_w;
        ub = {32'd0, b} & mask_w;
        sa = ua[w-1] ? $signed(ua - (64'd1 << w)) : $signed(ua);
        sb = ub[w-1] ? $signed(ub - (64'd1 << w)) : $signed(ub);
        if (!op[1]) begin
            if (!op[0]) return $unsigned(sa * sb) & mask_r;
            return (ua * ub) & mask_r;
        end
        if (ub == 64'd0) return ((ua << w) | mask_w) & mask_r;
        if (!op[0]) begin
            q = $unsigned(sa / sb);
            r = $unsigned(sa % sb);
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        return (((r & mask_w) << w) | (q & mask_w)) & mask_r;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? bus8.done : bus32.done;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic [63:0] get_result(input int w);
        return (w == 8) ? {48'd0, bus8.result} : bus32.result;
    endfunction

    task automatic drive(input int w, input logic st, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            bus8.start     = st;
            bus8.op        = op;
            bus8.operand_1 = a[7:0];
            bus8.operand_2 = b[7:0];
        end else begin
            bus32.start     = st;
            bus32.op        = op;
            bus32.operand_1 = a;
            bus32.operand_2 = b;
        end
    endtask

    // Present a request for one edge, then scramble the inputs to prove they were latched.
    task automatic start_op(input int w, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(w, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 2'($urandom), $urandom, $urandom);
    endtask

    // Cycle 1 is the cycle right after the start edge; bounded wait for done.
    task automatic wait_done(input int w, output int cyc, output logic [63:0] res);
        cyc = 1;
        @(negedge clk);
        while (!get_done(w) && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        res = get_result(w);
    endtask

    task automatic run_op(input int w, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input string tag);
        int          cyc;
        logic [63:0] res;
        int          exp_cyc;
        exp_cyc = (op[1] && ((b & ((64'd1 << w) - 1)) == 0)) ? 1 : w + 1;
        start_op(w, op, a, b);
        wait_done(w, cyc, res);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_busy_at_done"}, 64'(get_busy(w)), 64'd1);
        @(negedge clk);
        check({tag, "_single_pulse"}, {62'd0, get_done(w), get_busy(w)}, 64'd0);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return (m >> 1) + 32'd1;
            2:       return m;
            3:       return 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    initial begin
        int          cyc;
        int          pulses;
        logic [63:0] res;
        logic [63:0] prev;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus32.flush = 1'b0;
        bus8.flush  = 1'b0;
        drive(32, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(8, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state32", {bus32.busy, bus32.done, bus32.result[61:0]}, 64'd0);
        check("reset_state8", {46'd0, bus8.busy, bus8.done, bus8.result}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {bus32.busy, bus32.done, bus32.result[61:0]}, 64'd0);

        // Directed corner cases
        run_op(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_op(32, 2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg");
        run_op(32, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_min");
        run_op(32, 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
        run_op(32, 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "divu");
        run_op(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_min");
        run_op(32, 2'b11, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, "divu_zero");
        run_op(32, 2'b10, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, "div_zero");

        // Flush at cycle 10 of a MULT: no done, result kept, then a normal operation
        prev = bus32.result;
        start_op(32, 2'b00, 32'd1234, 32'hFFFF_FF00);
        repeat (10) @(negedge clk);
        bus32.flush = 1'b1;
        @(posedge clk);
        #1;
        bus32.flush = 1'b0;
        @(negedge clk);
        check("flush_idle", {62'd0, bus32.busy, bus32.done}, 64'd0);
        check("flush_result_kept", bus32.result, prev);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done) pulses++;
        end
        check("flush_no_done", 64'(pulses), 64'd0);
        run_op(32, 2'b00, 32'd1234, 32'hFFFF_FF00, ref_model(32, 2'b00, 32'd1234, 32'hFFFF_FF00),
               "after_flush");

        // Flush while in DONE masks done combinationally
        start_op(32, 2'b11, 32'd77, 32'd5);
        wait_done(32, cyc, res);
        bus32.flush = 1'b1;
        #1;
        check("flush_in_done_masks", 64'(bus32.done), 64'd0);
        @(negedge clk);
        bus32.flush = 1'b0;
        check("flush_in_done_idle", 64'(bus32.busy), 64'd0);

        // flush && start in IDLE: start ignored
        @(negedge clk);
        bus32.flush = 1'b1;
        drive(32, 1'b1, 2'b01, 32'd3, 32'd3);
        @(posedge clk);
        #1;
        bus32.flush = 1'b0;
        drive(32, 1'b0, 2'b01, 32'd0, 32'd0);
        @(negedge clk);
        check("flush_blocks_start", 64'(bus32.busy), 64'd0);

        // start held high through DONE: one pulse, re-accepted only after IDLE
        @(negedge clk);
        drive(32, 1'b1, 2'b11, 32'd100, 32'd7);
        wait_done(32, cyc, res);
        check("held_start_result", res, 64'h0000_0002_0000_000E);
        @(negedge clk);
        check("held_start_idle", {62'd0, bus32.busy, bus32.done}, 64'd0);
        @(negedge clk);
        check("held_start_reaccept", 64'(bus32.busy), 64'd1);
        drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
        wait_done(32, cyc, res);
        check("held_start_second", res, 64'h0000_0002_0000_000E);
        check("held_start_second_lat", 64'(cyc), 64'd32);

        // Async reset mid-DIV clears outputs without a clock edge
        start_op(32, 2'b10, 32'hFFFF_0000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst", {bus32.busy, bus32.done, bus32.result[61:0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("async_rst_idle", 64'(bus32.busy), 64'd0);

        // Randomized sweeps
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = pick(32);
            b  = pick(32);
            run_op(32, op, a, b, ref_model(32, op, a, b), $sformatf("rand32_%0d", i));
        end
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            a  = pick(8);
            b  = pick(8);
            run_op(8, op, a, b, ref_model(8, op, a, b), $sformatf("rand8_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
